playback_ctrl: RTL and testbench
================================

# playback_ctrl

Playback controller for the note chart. Sequences gameplay (idle, count-in, play, pause, done) and generates the eighth-note tick, the chart position index and the pause qualifier that drive the note chart ROM/sender. Sits between the player-facing control inputs (start, pause, restart buttons, already debounced to single-cycle pulses) and the note sender and scoring logic.

## Interface
- TICK_DIV, 13157895: CLOCK_50 cycles per eighth note; must be ≥ 2.
- SONG_LEN, 304: chart length in eighth notes; positions 0..SONG_LEN-1; must be ≤ 512.
- COUNTIN_TICKS, 8: eighth-note ticks of count-in before play; 0..15.

- CLOCK_50  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a song from IDLE or DONE.
- pause_req  in  1  one-cycle pulse; toggles PLAY ↔ PAUSED.
- restart  in  1  one-cycle pulse; aborts to IDLE from any state.
- state  out  3  0 IDLE, 1 COUNTIN, 2 PLAY, 3 PAUSED, 4 DONE.
- pos  out  9  current chart position (eighth-note index).
- tick  out  1  one-cycle pulse, the same cycle pos advances in PLAY.
- countin_pulse  out  1  one-cycle pulse per count-in tick.
- countin_left  out  4  count-in ticks remaining.
- note_pause  out  1  high in every state except PLAY.
- song_done  out  1  one-cycle pulse at end of chart.

## Operation
- Internal divider cnt (25 bits) counts 0..TICK_DIV-1. A "wrap" is a counted cycle with cnt == TICK_DIV-1; cnt → 0.
- The divider counts only in COUNTIN and PLAY. It holds in PAUSED. It is cleared to 0 on entry to COUNTIN, on entry to PLAY from COUNTIN, and on entry to IDLE.
- IDLE: pos 0. start → COUNTIN with countin_left = COUNTIN_TICKS. If COUNTIN_TICKS == 0, start → PLAY directly.
- COUNTIN: on each wrap, countin_pulse = 1 and countin_left decrements. A wrap with countin_left == 1 → PLAY, countin_left = 0.
- PLAY: on each wrap, tick = 1 and pos increments. A wrap with pos == SONG_LEN-1 sets pos = 0 and song_done = 1, then follows the Configuration section. pause_req → PAUSED.
- PAUSED: pos and cnt frozen. pause_req → PLAY; the divider resumes from its held value.
- DONE: pos 0. start → COUNTIN, same as from IDLE.
- restart in any state → IDLE. restart in IDLE is a no-op.
- Priority within one cycle: reset > restart > pause_req > start > wrap.
  - pause_req coinciding with a wrap in PLAY: enter PAUSED, no tick, cnt holds at TICK_DIV-1. The wrap occurs on the first cycle after resume.
  - pause_req in IDLE, COUNTIN or DONE is ignored. start outside IDLE/DONE is ignored.
- note_pause and state are registered, and change on the same edge as the state register.

## Timing
- Reset values: state 0, pos 0, tick 0, countin_pulse 0, countin_left 0, note_pause 1, song_done 0, cnt 0.
- Reset mid-operation: all outputs return to their reset values on the next edge.
- Latency:
  - Input pulse sampled at edge N → new state visible after edge N.
  - In PLAY, the first tick follows TICK_DIV counted cycles after entry.
  - tick, pos update and song_done are coincident, all registered.
- Tick period in PLAY is exactly TICK_DIV cycles, excluding cycles spent in PAUSED.
- pos never exceeds SONG_LEN-1.

## Configuration
- PLAYBACK_LOOP_EN defined: the end-of-chart wrap stays in PLAY with pos = 0, so the chart repeats indefinitely. song_done still pulses on each pass.
- PLAYBACK_LOOP_EN undefined: the end-of-chart wrap goes to DONE. note_pause rises and pos = 0.

## Test plan
Bench parameters: TICK_DIV=4, SONG_LEN=6, COUNTIN_TICKS=2.
- Reset held 2 cycles, then released → state 0, note_pause 1, pos 0, all pulses 0.
- start pulse → state 1, countin_left 2. countin_pulse at +4 and +8 cycles. state 2 after the second pulse; note_pause falls on the same edge.
- In PLAY → tick every 4 cycles; pos 1,2,3,4,5,0. song_done coincides with pos 5→0. Without PLAYBACK_LOOP_EN, state becomes 4. With it, state stays 2 and the next tick gives pos 1.
- pause_req 2 cycles after a tick → state 3, pos frozen for 10 cycles. Second pause_req → next tick arrives 2 cycles after resume.
- pause_req on a wrap cycle → no tick, state 3. After resume, tick on the first counted cycle.
- restart during PAUSED at pos 3 → state 0, pos 0, note_pause 1. Simultaneous start and restart in DONE → state 0.

Source files
------------

// File: rtl/playback_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : playback_ctrl
// Description : Gameplay sequencer for the note chart. Walks through
//               IDLE -> COUNTIN -> PLAY <-> PAUSED -> DONE. It generates the
//               eighth-note tick, the chart position index and the pause
//               qualifier for the note chart ROM/sender and the scoring logic.
//
// Parameters  : TICK_DIV      - CLOCK_50 cycles per eighth note (>= 2)
//               SONG_LEN      - chart length in eighth notes (<= 512)
//               COUNTIN_TICKS - eighth-note ticks of count-in (0..15)
//
// Ports       : CLOCK_50      in   system clock, rising edge
//               reset         in   synchronous, active-high reset
//               start         in   pulse, begin a song from IDLE or DONE
//               pause_req     in   pulse, toggle PLAY <-> PAUSED
//               restart       in   pulse, abort to IDLE from any state
//               state         out  0 IDLE, 1 COUNTIN, 2 PLAY, 3 PAUSED, 4 DONE
//               pos           out  current chart position (eighth-note index)
//               tick          out  pulse, coincident with a pos advance in PLAY
//               countin_pulse out  pulse, one per count-in tick
//               countin_left  out  count-in ticks remaining
//               note_pause    out  high in every state except PLAY
//               song_done     out  pulse, end of chart reached
//
// Build macro : PLAYBACK_LOOP_EN - when defined, the end of the chart wraps
//               back to position 0 and play continues. When undefined, the
//               end of the chart enters DONE.
//
// Revision    : 1.0 - initial release
// ============================================================================
module playback_ctrl #(
  parameter int unsigned TICK_DIV      = 13157895,
  parameter int unsigned SONG_LEN      = 304,
  parameter int unsigned COUNTIN_TICKS = 8
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       start,
  input  logic       pause_req,
  input  logic       restart,
  output logic [2:0] state,
  output logic [8:0] pos,
  output logic       tick,
  output logic       countin_pulse,
  output logic [3:0] countin_left,
  output logic       note_pause,
  output logic       song_done
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_COUNTIN = 3'd1,
    ST_PLAY    = 3'd2,
    ST_PAUSED  = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

  localparam logic [24:0] C_CNT_LAST = 25'(TICK_DIV - 1);
  localparam logic [8:0]  C_POS_LAST = 9'(SONG_LEN - 1);
  localparam logic [3:0]  C_COUNTIN  = 4'(COUNTIN_TICKS);

  // State entered when the last chart position has been played.
`ifdef PLAYBACK_LOOP_EN
  localparam state_e C_END_STATE = ST_PLAY;
`else
  localparam state_e C_END_STATE = ST_DONE;
`endif

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  state_e      state_q,         state_d;
  logic [24:0] cnt_q,           cnt_d;
  logic [8:0]  pos_q,           pos_d;
  logic [3:0]  countin_left_q,  countin_left_d;
  logic        tick_q,          tick_d;
  logic        countin_pulse_q, countin_pulse_d;
  logic        song_done_q,     song_done_d;
  logic        note_pause_q,    note_pause_d;

  // --------------------------------------------------------------------------
  // Event decode
  //
  // Every event below already has the priority order folded in:
  // restart beats pause_req, pause_req beats start, and both beat a divider
  // wrap. The next-state and datapath processes can therefore act on each
  // event without re-checking the others.
  // --------------------------------------------------------------------------
  logic w_in_idle;
  logic w_in_countin;
  logic w_in_play;
  logic w_in_paused;
  logic w_in_done;
  logic w_bad_state;
  logic w_cnt_last;
  logic w_abort;
  logic w_launch;
  logic w_pause_in;
  logic w_resume;
  logic w_counting;
  logic w_cin_wrap;
  logic w_cin_last;
  logic w_play_wrap;
  logic w_end_wrap;

  always_comb begin
    w_in_idle    = (state_q == ST_IDLE);
    w_in_countin = (state_q == ST_COUNTIN);
    w_in_play    = (state_q == ST_PLAY);
    w_in_paused  = (state_q == ST_PAUSED);
    w_in_done    = (state_q == ST_DONE);
    w_bad_state  = !(w_in_idle || w_in_countin || w_in_play ||
                     w_in_paused || w_in_done);

    w_cnt_last   = (cnt_q == C_CNT_LAST);

    // A restart while already idle changes nothing. It still blocks a
    // start that arrives in the same cycle.
    w_abort      = restart && !w_in_idle;
    w_launch     = !restart && start && (w_in_idle || w_in_done);

    // pause_req has an effect only in PLAY and PAUSED.
    w_pause_in   = !restart && pause_req && w_in_play;
    w_resume     = !restart && pause_req && w_in_paused;

    // The divider advances during count-in, and during play on any cycle
    // where no pause is taken. A pause that lands on the wrap cycle leaves
    // cnt at its last value, so the wrap occurs on the first cycle after
    // the resume.
    w_counting   = !restart && (w_in_countin || (w_in_play && !pause_req));

    w_cin_wrap   = w_counting && w_in_countin && w_cnt_last;
    w_cin_last   = w_cin_wrap && (countin_left_q == 4'd1);
    w_play_wrap  = w_counting && w_in_play && w_cnt_last;
    w_end_wrap   = w_play_wrap && (pos_q == C_POS_LAST);
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    if (w_bad_state || w_abort) begin
      state_d = ST_IDLE;
    end else if (w_launch) begin
      // With no count-in configured, start goes straight to PLAY.
      state_d = (C_COUNTIN == 4'd0) ? ST_PLAY : ST_COUNTIN;
    end else if (w_pause_in) begin
      state_d = ST_PAUSED;
    end else if (w_resume) begin
      state_d = ST_PLAY;
    end else if (w_cin_last) begin
      state_d = ST_PLAY;
    end else if (w_end_wrap) begin
      state_d = C_END_STATE;
    end

    // note_pause is registered so that it changes on the same edge as state.
    note_pause_d = (state_d != ST_PLAY);
  end

  // --------------------------------------------------------------------------
  // Eighth-note divider
  //
  // The divider is cleared when entering IDLE, COUNTIN, or PLAY from
  // COUNTIN, so the first tick of each phase comes exactly TICK_DIV counted
  // cycles after entry. It is not cleared on resume from PAUSED.
  // --------------------------------------------------------------------------
  always_comb begin
    cnt_d = cnt_q;
    if (w_bad_state || w_abort || w_launch || w_cin_last) begin
      cnt_d = '0;
    end else if (w_counting) begin
      cnt_d = w_cnt_last ? '0 : (cnt_q + 25'd1);
    end
  end

  // --------------------------------------------------------------------------
  // Count-in bookkeeping
  // --------------------------------------------------------------------------
  always_comb begin
    countin_left_d  = countin_left_q;
    countin_pulse_d = 1'b0;
    if (w_bad_state || w_abort) begin
      countin_left_d = '0;
    end else if (w_launch) begin
      countin_left_d = C_COUNTIN;
    end else if (w_cin_wrap) begin
      countin_pulse_d = 1'b1;
      countin_left_d  = countin_left_q - 4'd1;
    end
  end

  // --------------------------------------------------------------------------
  // Chart position, tick and end-of-chart pulse
  // --------------------------------------------------------------------------
  always_comb begin
    pos_d       = pos_q;
    tick_d      = 1'b0;
    song_done_d = 1'b0;
    if (w_bad_state || w_abort || w_launch) begin
      pos_d = '0;
    end else if (w_play_wrap) begin
      tick_d = 1'b1;
      if (w_end_wrap) begin
        // The position never goes past the last chart entry. It wraps to
        // 0 whether play stops or loops.
        pos_d       = '0;
        song_done_d = 1'b1;
      end else begin
        pos_d = pos_q + 9'd1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      cnt_q           <= '0;
      pos_q           <= '0;
      countin_left_q  <= '0;
      tick_q          <= 1'b0;
      countin_pulse_q <= 1'b0;
      song_done_q     <= 1'b0;
      note_pause_q    <= 1'b1;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      pos_q           <= pos_d;
      countin_left_q  <= countin_left_d;
      tick_q          <= tick_d;
      countin_pulse_q <= countin_pulse_d;
      song_done_q     <= song_done_d;
      note_pause_q    <= note_pause_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign state         = state_q;
  assign pos           = pos_q;
  assign tick          = tick_q;
  assign countin_pulse = countin_pulse_q;
  assign countin_left  = countin_left_q;
  assign note_pause    = note_pause_q;
  assign song_done     = song_done_q;

endmodule
`default_nettype wire

// File: tb/tb_playback_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_playback_ctrl
// Description : Self-checking bench for playback_ctrl. A cycle-level
//               behavioural model predicts every output and is compared on
//               each falling edge. A directed walk-through pins hand-computed
//               values, and randomized control pulses follow it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_playback_ctrl;

  localparam int TICK_DIV      = 4;
  localparam int SONG_LEN      = 6;
  localparam int COUNTIN_TICKS = 2;

  localparam int S_IDLE    = 0;
  localparam int S_COUNTIN = 1;
  localparam int S_PLAY    = 2;
  localparam int S_PAUSED  = 3;
  localparam int S_DONE    = 4;

`ifdef PLAYBACK_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  logic       clk       = 1'b0;
  logic       reset     = 1'b1;
  logic       start     = 1'b0;
  logic       pause_req = 1'b0;
  logic       restart   = 1'b0;
  logic [2:0] state;
  logic [8:0] pos;
  logic       tick;
  logic       countin_pulse;
  logic [3:0] countin_left;
  logic       note_pause;
  logic       song_done;

  playback_ctrl #(
    .TICK_DIV      (TICK_DIV),
    .SONG_LEN      (SONG_LEN),
    .COUNTIN_TICKS (COUNTIN_TICKS)
  ) dut (
    .CLOCK_50      (clk),
    .reset         (reset),
    .start         (start),
    .pause_req     (pause_req),
    .restart       (restart),
    .state         (state),
    .pos           (pos),
    .tick          (tick),
    .countin_pulse (countin_pulse),
    .countin_left  (countin_left),
    .note_pause    (note_pause),
    .song_done     (song_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Behavioural model. elapsed counts the cycles that were actually counted
  // since the last tick or phase entry. An event fires when it reaches
  // TICK_DIV.
  // --------------------------------------------------------------------------
  int m_state, m_pos, m_elapsed, m_left;
  bit m_tick, m_cp, m_sd;
  bit m_valid = 1'b0;

  always @(posedge clk) begin : model
    int ns, np, ne, nl;
    bit nt, ncp, nsd;
    if (reset) begin
      m_state   <= S_IDLE;
      m_pos     <= 0;
      m_elapsed <= 0;
      m_left    <= 0;
      m_tick    <= 1'b0;
      m_cp      <= 1'b0;
      m_sd      <= 1'b0;
      m_valid   <= 1'b1;
    end else begin
      ns = m_state; np = m_pos; ne = m_elapsed; nl = m_left;
      nt = 1'b0; ncp = 1'b0; nsd = 1'b0;
      if (restart) begin
        if (m_state != S_IDLE) begin
          ns = S_IDLE; np = 0; ne = 0; nl = 0;
        end
      end else begin
        case (m_state)
          S_IDLE, S_DONE: begin
            if (start) begin
              np = 0; ne = 0;
              if (COUNTIN_TICKS == 0) ns = S_PLAY;
              else begin ns = S_COUNTIN; nl = COUNTIN_TICKS; end
            end
          end
          S_COUNTIN: begin
            ne = m_elapsed + 1;
            if (ne == TICK_DIV) begin
              ne = 0; ncp = 1'b1; nl = m_left - 1;
              if (nl == 0) ns = S_PLAY;
            end
          end
          S_PLAY: begin
            if (pause_req) ns = S_PAUSED;
            else begin
              ne = m_elapsed + 1;
              if (ne == TICK_DIV) begin
                ne = 0; nt = 1'b1;
                np = (m_pos + 1) % SONG_LEN;
                if (np == 0) begin
                  nsd = 1'b1;
                  ns  = LOOP ? S_PLAY : S_DONE;
                end
              end
            end
          end
          S_PAUSED: if (pause_req) ns = S_PLAY;
          default: ns = S_IDLE;
        endcase
      end
      m_state   <= ns;
      m_pos     <= np;
      m_elapsed <= ne;
      m_left    <= nl;
      m_tick    <= nt;
      m_cp      <= ncp;
      m_sd      <= nsd;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("state",         int'(state),         m_state);
      chk("pos",           int'(pos),           m_pos);
      chk("tick",          int'(tick),          int'(m_tick));
      chk("countin_pulse", int'(countin_pulse), int'(m_cp));
      chk("countin_left",  int'(countin_left),  m_left);
      chk("note_pause",    int'(note_pause),    int'(m_state != S_PLAY));
      chk("song_done",     int'(song_done),     int'(m_sd));
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers (inputs change on falling edges only)
  // --------------------------------------------------------------------------
  task automatic drive(input bit s, input bit p, input bit r);
    start = s; pause_req = p; restart = r;
    @(negedge clk);
    start = 1'b0; pause_req = 1'b0; restart = 1'b0;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    wait_cyc(2);
    reset = 1'b0;
    chk("lit_reset_state", int'(state), 0);
    chk("lit_reset_np",    int'(note_pause), 1);
    chk("lit_reset_pos",   int'(pos), 0);

    // Count-in, then one full pass of the chart.
    drive(1'b1, 1'b0, 1'b0);
    chk("lit_cin_state", int'(state), 1);
    chk("lit_cin_left",  int'(countin_left), 2);
    wait_cyc(3);
    chk("lit_cin_nopulse", int'(countin_pulse), 0);
    wait_cyc(1);
    chk("lit_cin_pulse1", int'(countin_pulse), 1);
    chk("lit_cin_left1",  int'(countin_left), 1);
    wait_cyc(4);
    chk("lit_play_state", int'(state), 2);
    chk("lit_play_np",    int'(note_pause), 0);
    chk("lit_cin_pulse2", int'(countin_pulse), 1);
    wait_cyc(4);
    chk("lit_tick1", int'(tick), 1);
    chk("lit_pos1",  int'(pos), 1);
    wait_cyc(16);
    chk("lit_pos5", int'(pos), 5);
    wait_cyc(4);
    chk("lit_done_pulse", int'(song_done), 1);
    chk("lit_done_pos",   int'(pos), 0);
    chk("lit_end_state",  int'(state), LOOP ? 2 : 4);
`ifdef PLAYBACK_LOOP_EN
    wait_cyc(4);
    chk("lit_loop_pos1", int'(pos), 1);
    drive(1'b0, 1'b0, 1'b1);
    chk("lit_restart_state", int'(state), 0);
`else
    drive(1'b1, 1'b0, 1'b1);
    chk("lit_start_restart_state", int'(state), 0);
    chk("lit_start_restart_np",    int'(note_pause), 1);
`endif

    // Pause mid-period, pause on a wrap, then restart while paused.
    drive(1'b1, 1'b0, 1'b0);
    wait_cyc(8);
    chk("lit_p_play", int'(state), 2);
    wait_cyc(4);
    chk("lit_p_pos1", int'(pos), 1);
    wait_cyc(2);
    drive(1'b0, 1'b1, 1'b0);
    chk("lit_p_paused", int'(state), 3);
    wait_cyc(10);
    chk("lit_p_hold_state", int'(state), 3);
    chk("lit_p_hold_pos",   int'(pos), 1);
    drive(1'b0, 1'b1, 1'b0);
    chk("lit_p_resumed", int'(state), 2);
    wait_cyc(1);
    chk("lit_p_notick", int'(tick), 0);
    wait_cyc(1);
    chk("lit_p_tick", int'(tick), 1);
    chk("lit_p_pos2", int'(pos), 2);
    wait_cyc(3);
    drive(1'b0, 1'b1, 1'b0);
    chk("lit_w_paused", int'(state), 3);
    chk("lit_w_notick", int'(tick), 0);
    chk("lit_w_pos",    int'(pos), 2);
    drive(1'b0, 1'b1, 1'b0);
    chk("lit_w_resumed", int'(state), 2);
    wait_cyc(1);
    chk("lit_w_tick", int'(tick), 1);
    chk("lit_w_pos3", int'(pos), 3);
    drive(1'b0, 1'b1, 1'b0);
    chk("lit_r_paused", int'(state), 3);
    drive(1'b0, 1'b0, 1'b1);
    chk("lit_r_state", int'(state), 0);
    chk("lit_r_pos",   int'(pos), 0);
    chk("lit_r_np",    int'(note_pause), 1);

    // Randomized control pulses.
    for (int i = 0; i < 3000; i++) begin
      start     = ($urandom_range(0, 7)   == 0);
      pause_req = ($urandom_range(0, 9)   == 0);
      restart   = ($urandom_range(0, 79)  == 0);
      reset     = ($urandom_range(0, 399) == 0);
      @(negedge clk);
    end
    start = 1'b0; pause_req = 1'b0; restart = 1'b0; reset = 1'b0;
    wait_cyc(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
